// File: rtl/ip_codma_mem_responder.sv
// ip_codma_mem_responder: codma memory-bus slave; arbitrates, grants and streams 64-bit beats to/from a word memory.
// Define CODMA_MEM_RESP_STALL_EN to insert a one-cycle gap after every read beat except the last.
module ip_codma_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int RD_LATENCY  = 2
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        read_i,
  input  logic        write_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  size_i,
  input  logic        write_valid_i,
  input  logic [63:0] write_data_i,
  output logic        grant_o,
  output logic        read_valid_o,
  output logic [63:0] read_data_o,
  output logic        error_o,
  output logic        busy_o
);
  localparam int AW = $clog2(DEPTH_WORDS);
`ifdef CODMA_MEM_RESP_STALL_EN
  localparam logic STALL = 1'b1;
`else
  localparam logic STALL = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, GRANT, RD_WAIT, RD_DATA, WR_DATA} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [1:0] beat_q, beat_d, size_q, size_d, beats_m1;
  logic [3:0] cnt_q, cnt_d;
  logic rd_q, rd_d, gap_q, gap_d;
  logic grant_q, grant_d, valid_q, valid_d, error_q, error_d, busy_q, busy_d;
  logic [63:0] data_q, data_d;
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] mask, last_w;
  logic req, legal;
  assign req = read_i | write_i;
  always_comb begin
    mask = (32'd4 << size_i[1:0]) - 32'd1;
    last_w = {2'b00, addr_i[31:2]} + (32'd1 << size_i[1:0]) - 32'd1;
    legal = size_i < 4'd4 && (addr_i & mask) == 32'd0 && last_w < 32'(DEPTH_WORDS);
    beats_m1 = size_i[1:0] == 2'd3 ? 2'd3 : size_i[1:0] == 2'd2 ? 2'd1 : 2'd0;
  end
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      beat_q  <= '0;
      size_q  <= '0;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      gap_q   <= 1'b0;
      grant_q <= 1'b0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
      busy_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      beat_q  <= beat_d;
      size_q  <= size_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      gap_q   <= gap_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      error_q <= error_d;
      busy_q  <= busy_d;
      data_q  <= data_d;
    end
  end
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    beat_d  = beat_q;
    size_d  = size_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    gap_d   = gap_q;
    unique case (state_q)
      IDLE: if (req) begin
        rd_d    = read_i;
        size_d  = size_i[1:0];
        ptr_d   = addr_i[AW+1:2];
        beat_d  = beats_m1;
        gap_d   = 1'b0;
        state_d = legal ? GRANT : IDLE;
      end
      GRANT: begin
        cnt_d   = 4'(RD_LATENCY - 2);
        state_d = !rd_q ? WR_DATA : RD_LATENCY == 1 ? RD_DATA : RD_WAIT;
      end
      RD_WAIT: begin
        cnt_d   = cnt_q - 4'd1;
        state_d = cnt_q == 4'd0 ? RD_DATA : RD_WAIT;
      end
      RD_DATA: if (gap_q) gap_d = 1'b0;
        else if (beat_q == 2'd0) state_d = IDLE;
        else begin
          ptr_d  = ptr_q + AW'(2);
          beat_d = beat_q - 2'd1;
          gap_d  = STALL;
        end
      WR_DATA: if (write_valid_i) begin
        if (beat_q == 2'd0) state_d = IDLE;
        else begin
          ptr_d  = ptr_q + AW'(2);
          beat_d = beat_q - 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // Outputs are registered from the next-state view so each beat appears in the cycle its state is active.
  always_comb begin
    grant_d = state_d == GRANT;
    busy_d  = state_d != IDLE;
    error_d = state_q == IDLE && req && !legal;
    valid_d = state_d == RD_DATA && !gap_d;
    data_d  = valid_d ? {size_d == 2'd0 ? 32'd0 : mem[ptr_d + AW'(1)], mem[ptr_d]} : 64'd0;
  end
  always_ff @(posedge clk_i) begin
    if (state_q == WR_DATA && write_valid_i) begin
      mem[ptr_q] <= write_data_i[31:0];
      if (size_q != 2'd0) mem[ptr_q + AW'(1)] <= write_data_i[63:32];
    end
  end
  assign grant_o      = grant_q;
  assign read_valid_o = valid_q;
  assign read_data_o  = data_q;
  assign error_o      = error_q;
  assign busy_o       = busy_q;
endmodule
